spc_seq_ctrl: RTL and testbench

Sequencing controller for long single-parity-check (SPC) nodes in the polar SC decoder. It accepts an SPC node of 4..4·MAX_CHUNK LLRs as a stream of 4-LLR chunks, makes hard decisions, and tracks running parity and the global minimum-|LLR| position. After the last chunk it flips the least-reliable bit if parity is odd, then streams the corrected bits back out 4 per beat. It sits between the LLR memory read path and the partial-sum/bit memory write path, and covers SPC nodes longer than the 4-LLR combinational SPC function.

---
 rtl/spc_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_spc_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spc_seq_ctrl.sv
// Sequencing controller for long SPC nodes: streams 4-LLR chunks in, tracks parity and
// the least-reliable position, flips it on odd parity, then streams corrected bits out.
module spc_seq_ctrl #(
    parameter int LLR_W     = 6,
    parameter int MAX_CHUNK = 8,
    parameter int IDX_W     = $clog2(4 * MAX_CHUNK)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MAX_CHUNK):0] num_chunk,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*LLR_W-1:0]         in_llr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_bits,
    output logic                       out_last,
    output logic                       parity_odd,
    output logic [IDX_W-1:0]           min_idx,
    output logic                       busy,
    output logic                       done
);
    localparam int NC_W  = $clog2(MAX_CHUNK) + 1;
    localparam int CNT_W = (MAX_CHUNK > 1) ? $clog2(MAX_CHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIX, S_OUT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [NC_W-1:0]  r_num;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ocnt;
    logic [3:0]       r_buf [MAX_CHUNK];
    logic             r_parity;
    logic [LLR_W-1:0] r_min_val;
    logic [IDX_W-1:0] r_min_idx;
    logic             r_done;

    logic             w_start_ok;
    logic [NC_W-1:0]  w_num_m1;
    logic             w_in_last;
    logic             w_out_last;
    logic [LLR_W-1:0] w_elem [4];
    logic [LLR_W-1:0] w_abs  [4];
    logic [3:0]       w_hard;
    logic [LLR_W-1:0] w_cmin_val;
    logic [1:0]       w_cmin_e;
    logic [IDX_W-1:0] w_cmin_idx;

    assign w_start_ok = start && (num_chunk != '0) && (num_chunk <= NC_W'(MAX_CHUNK));
    assign w_num_m1   = r_num - NC_W'(1);
    assign w_in_last  = (NC_W'(r_cnt) == w_num_m1);
    assign w_out_last = (NC_W'(r_ocnt) == w_num_m1);

    // Unsigned magnitude: the most negative code maps to 2^(LLR_W-1), the largest value.
    always_comb begin
        w_hard     = '0;
        w_cmin_val = '0;
        w_cmin_e   = '0;
        for (int unsigned e = 0; e < 4; e++) begin
            w_elem[e]     = in_llr[(3-e)*LLR_W +: LLR_W];
            w_hard[3-e]   = w_elem[e][LLR_W-1];
            w_abs[e]      = w_elem[e][LLR_W-1] ? (~w_elem[e] + LLR_W'(1)) : w_elem[e];
        end
        w_cmin_val = w_abs[0];
        for (int unsigned e = 1; e < 4; e++) begin
            if (w_abs[e] < w_cmin_val) begin
                w_cmin_val = w_abs[e];
                w_cmin_e   = 2'(e);
            end
        end
    end

    assign w_cmin_idx = IDX_W'({r_cnt, w_cmin_e});

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = S_LOAD;
            S_LOAD: if (in_valid && w_in_last) w_next = S_FIX;
            S_FIX:  w_next = S_OUT;
            S_OUT:  if (out_ready && w_out_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num     <= '0;
            r_cnt     <= '0;
            r_ocnt    <= '0;
            r_parity  <= 1'b0;
            r_min_val <= '0;
            r_min_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_OUT) && out_ready && w_out_last;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_num     <= num_chunk;
                        r_cnt     <= '0;
                        r_ocnt    <= '0;
                        r_parity  <= 1'b0;
                        r_min_val <= '0;
                        r_min_idx <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_buf[r_cnt] <= w_hard;
                        r_parity     <= r_parity ^ (^w_hard);
                        // Strict compare across chunks keeps the earliest position on ties.
                        if (r_cnt == '0 || w_cmin_val < r_min_val) begin
                            r_min_val <= w_cmin_val;
                            r_min_idx <= w_cmin_idx;
                        end
                        if (!w_in_last) r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (r_parity)
                        r_buf[r_min_idx[IDX_W-1:2]][~r_min_idx[1:0]] <=
                            ~r_buf[r_min_idx[IDX_W-1:2]][~r_min_idx[1:0]];
                end
                S_OUT: begin
                    if (out_ready) r_ocnt <= r_ocnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = (r_state == S_OUT);
    assign busy       = (r_state != S_IDLE);
    assign out_bits   = out_valid ? r_buf[r_ocnt] : '0;
    assign out_last   = out_valid && w_out_last;
    assign parity_odd = r_parity;
    assign min_idx    = r_min_idx;
    assign done       = r_done;
endmodule

// File: tb/tb_spc_seq_ctrl.sv
// Self-checking bench for spc_seq_ctrl: table-driven nodes, random nodes from a
// reference model, reset mid-LOAD and illegal starts; output beats checked via a queue.
module tb_spc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_chunk;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_llr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_bits;
    logic        out_last;
    logic        parity_odd;
    logic [4:0]  min_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    spc_seq_ctrl #(.LLR_W(6), .MAX_CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_chunk(num_chunk),
        .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_last(out_last), .parity_odd(parity_odd), .min_idx(min_idx),
        .busy(busy), .done(done)
    );

    typedef struct {
        int          num;
        logic [23:0] llr  [8];
        logic [3:0]  bits [8];
        logic        par;
        logic [4:0]  midx;
        bit          gaps;
        bit          stall;
    } vec_t;

    typedef struct {
        logic [3:0] bits;
        logic       last;
    } beat_t;

    beat_t sbq[$];
    int    checks = 0;
    int    errors = 0;
    vec_t  vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
        return {6'(a), 6'(b), 6'(c), 6'(d)};
    endfunction

    function automatic vec_t mkv(input int num, input logic par, input logic [4:0] midx,
                                 input bit gaps, input bit stall);
        vec_t v;
        v.num = num; v.par = par; v.midx = midx; v.gaps = gaps; v.stall = stall;
        for (int i = 0; i < 8; i++) begin
            v.llr[i]  = '0;
            v.bits[i] = '0;
        end
        return v;
    endfunction

    // Reference model: earliest global position of the strictly smallest magnitude.
    function automatic vec_t mk_rand(input int num);
        vec_t v;
        int   val, mag, best, bi;
        logic p;
        v = mkv(num, 1'b0, '0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        best = 0; bi = 0; p = 1'b0;
        for (int c = 0; c < num; c++) begin
            for (int e = 0; e < 4; e++) begin
                val = int'($urandom_range(0, 63)) - 32;
                v.llr[c][(3-e)*6 +: 6] = 6'(val);
                v.bits[c][3-e] = (val < 0);
                p = p ^ (val < 0);
                mag = (val < 0) ? -val : val;
                if ((c == 0 && e == 0) || mag < best) begin
                    best = mag;
                    bi   = c * 4 + e;
                end
            end
        end
        v.par  = p;
        v.midx = 5'(bi);
        if (p) v.bits[bi / 4][3 - (bi % 4)] = ~v.bits[bi / 4][3 - (bi % 4)];
        return v;
    endfunction

    task automatic run_node(input vec_t v);
        beat_t exp;
        bit    stalled;
        int    beat;
        chk("idle_busy", busy, 0);
        for (int c = 0; c < v.num; c++) sbq.push_back('{v.bits[c], (c == v.num - 1)});
        start = 1'b1;
        num_chunk = 4'(v.num);
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_done_clr", done, 0);
        for (int c = 0; c < v.num; c++) begin
            if (v.gaps && (c % 2 == 1)) begin
                in_valid = 1'b0;
                in_llr   = 24'($urandom);
                tick();
                chk("gap_in_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_llr   = v.llr[c];
            tick();
        end
        in_valid = 1'b0;
        in_llr   = 24'($urandom);
        chk("fix_out_valid", out_valid, 0);
        chk("fix_in_ready", in_ready, 0);
        tick();
        chk("lat_out_valid", out_valid, 1);
        stalled = 1'b0;
        beat = 0;
        while (beat < v.num) begin
            chk("out_valid", out_valid, 1);
            chk("parity_odd", parity_odd, v.par);
            chk("min_idx", min_idx, v.midx);
            if (v.stall && beat == 1 && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_bits", out_bits, sbq[0].bits);
                    chk("stall_out_last", out_last, sbq[0].last);
                end
                out_ready = 1'b1;
            end
            exp = sbq.pop_front();
            chk("out_bits", out_bits, exp.bits);
            chk("out_last", out_last, exp.last);
            beat++;
            tick();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_chunk = '0; in_valid = 1'b0; in_llr = '0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_parity", parity_odd, 0);
        chk("rst_min_idx", min_idx, 0);
        chk("rst_out_bits", out_bits, 0);
        rst = 1'b0;
        tick();

        foreach (vt[i]) vt[i] = mkv(1, 1'b0, '0, 1'b0, 1'b0);
        vt[0] = mkv(1, 1'b0, 5'd2, 1'b0, 1'b0);
        vt[0].llr[0] = pk(-4, -6, 1, 9);   vt[0].bits[0] = 4'b1100;
        vt[1] = mkv(1, 1'b1, 5'd3, 1'b0, 1'b0);
        vt[1].llr[0] = pk(5, -3, 7, 2);    vt[1].bits[0] = 4'b0101;
        vt[2] = mkv(3, 1'b0, 5'd4, 1'b0, 1'b0);
        vt[2].llr[0] = pk(9, 9, 9, -8);    vt[2].bits[0] = 4'b0001;
        vt[2].llr[1] = pk(3, 9, 9, 9);     vt[2].bits[1] = 4'b0000;
        vt[2].llr[2] = pk(9, -3, 9, 9);    vt[2].bits[2] = 4'b0100;
        vt[3] = mkv(1, 1'b1, 5'd3, 1'b0, 1'b0);
        vt[3].llr[0] = pk(-32, 31, 20, 1); vt[3].bits[0] = 4'b1001;
        vt[4] = mkv(4, 1'b1, 5'd0, 1'b1, 1'b1);
        vt[4].llr[0] = pk(1, 2, -3, 4);    vt[4].bits[0] = 4'b1010;
        vt[4].llr[1] = pk(-5, -6, 7, 8);   vt[4].bits[1] = 4'b1100;
        vt[4].llr[2] = pk(9, 10, -11, 12); vt[4].bits[2] = 4'b0010;
        vt[4].llr[3] = pk(13, 14, 15, -2); vt[4].bits[3] = 4'b0001;

        // Illegal chunk counts must leave the controller idle.
        start = 1'b1; num_chunk = 4'd0;
        tick();
        chk("illegal0_busy", busy, 0);
        chk("illegal0_in_ready", in_ready, 0);
        num_chunk = 4'd9;
        tick();
        chk("illegal9_busy", busy, 0);
        num_chunk = 4'd15;
        tick();
        chk("illegal15_busy", busy, 0);
        start = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_node(vt[i]);

        // Reset after 2 of 4 chunks.
        start = 1'b1; num_chunk = 4'd4;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_llr   = pk(-7, 3, 5, -9);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_parity", parity_odd, 0);
        chk("midrst_min_idx", min_idx, 0);
        tick();
        run_node(vt[1]);

        for (int i = 0; i < 6; i++) run_node(mk_rand((i == 0) ? 8 : int'($urandom_range(1, 8))));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
